// File: rtl/iter_muldiv_pkg.sv
// ----------------------------------------------------------------------------
// iter_muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit: operation
//   encodings, FSM state encodings and small decode helpers.
// ----------------------------------------------------------------------------
package iter_muldiv_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_MULT  = 2'b00;
   localparam op_t OP_MULTU = 2'b01;
   localparam op_t OP_DIV   = 2'b10;
   localparam op_t OP_DIVU  = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_FIX  = 2'd2;

   function automatic logic op_is_div(input op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/iter_muldiv_if.sv
// ----------------------------------------------------------------------------
// iter_muldiv_if
//   Datapath-side bundle of the multiply/divide unit.
//   master (datapath): drives start/op/srca/srcb/cancel/hi_we/lo_we/wd,
//                      observes busy/done/hi/lo.
//   slave  (unit)    : the reverse.
// ----------------------------------------------------------------------------
interface iter_muldiv_if
   import iter_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             start;
   op_t              op;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             cancel;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wd;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, srca, srcb, cancel, hi_we, lo_we, wd,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, srca, srcb, cancel, hi_we, lo_we, wd,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_step.sv
// ----------------------------------------------------------------------------
// muldiv_step
//   One combinational iteration of the unsigned multiply/divide datapath.
//   acc      : 2*WIDTH working register.
//              multiply: {partial sum, remaining multiplier bits}
//              divide  : {partial remainder, dividend/quotient bits}
//   opnd     : multiplicand (multiply) or divisor (divide), unsigned
//   op       : operation code, only multiply vs divide matters here
//   acc_next : working register after one iteration
// ----------------------------------------------------------------------------
module muldiv_step
   import iter_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opnd,
   input  op_t                op,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_sub;
   logic             fits;

   always_comb begin
      // Shift-add: add the multiplicand into the upper half when the current
      // multiplier LSB is set, then shift the whole accumulator right.
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

      // Restoring divide: shift the next dividend bit into the remainder.
      // The remainder is always below the divisor, so after a successful
      // subtract the result fits back into WIDTH bits.
      trial   = acc[2*WIDTH-1:WIDTH-1];
      fits    = (trial >= {1'b0, opnd});
      rem_sub = trial[WIDTH-1:0] - opnd;

      acc_next = '0;
      if (op_is_div(op)) begin
         if (fits) begin
            acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/iter_muldiv.sv
// ----------------------------------------------------------------------------
// iter_muldiv
//   Iterative multiply/divide unit with HI/LO result registers.
//   MULT/MULTU produce a 2*WIDTH product in HI:LO, DIV/DIVU put the quotient
//   in LO and the remainder in HI. One iteration per clock, WIDTH iterations
//   plus one sign-fix cycle. HI/LO may also be written directly while idle.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : iter_muldiv_if.slave (start/op/srca/srcb/cancel/hi_we/lo_we/wd in,
//           busy/done/hi/lo out, all outputs registered)
// ----------------------------------------------------------------------------
module iter_muldiv
   import iter_muldiv_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic           clk,
   input  logic           reset,
   iter_muldiv_if.slave   bus
);

   state_t             state_q, state_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   op_t                op_q, op_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               dz_q, dz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] step_acc;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc      (acc_q),
      .opnd     (opnd_q),
      .op       (op_q),
      .acc_next (step_acc)
   );

   always_comb begin
      a_neg = op_is_signed(bus.op) & bus.srca[WIDTH-1];
      b_neg = op_is_signed(bus.op) & bus.srcb[WIDTH-1];
      a_mag = a_neg ? -bus.srca : bus.srca;
      b_mag = b_neg ? -bus.srcb : bus.srcb;

      prod_fix = neg_q ? -acc_q : acc_q;
      // Divide by zero leaves the dividend magnitude in the remainder; with
      // the dividend-sign fix that reproduces the original dividend in HI.
      quo_fix  = dz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               cnt_d   = '0;
               op_d    = bus.op;
               busy_d  = 1'b1;
               neg_d   = a_neg ^ b_neg;
               rneg_d  = a_neg;
               dz_d    = op_is_div(bus.op) && (bus.srcb == '0);
               if (op_is_div(bus.op)) begin
                  acc_d  = {{WIDTH{1'b0}}, a_mag};
                  opnd_d = b_mag;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, b_mag};
                  opnd_d = a_mag;
               end
            end else begin
               if (bus.hi_we) hi_d = bus.wd;
               if (bus.lo_we) lo_d = bus.wd;
            end
         end

         S_RUN: begin
            if (bus.cancel) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               acc_d = step_acc;
               cnt_d = cnt_q + CNTW'(1);
               if (cnt_q == CNTW'(WIDTH - 1)) state_d = S_FIX;
            end
         end

         S_FIX: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            if (!bus.cancel) begin
               done_d = 1'b1;
               if (op_is_div(op_q)) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_MULT;
         opnd_q  <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// ----------------------------------------------------------------------------
// tb_iter_muldiv
//   Directed bench for iter_muldiv (WIDTH=32). Accepted operations push their
//   hand-computed HI/LO and completion cycle into a queue; a monitor pops and
//   compares whenever done is seen.
// ----------------------------------------------------------------------------
module tb_iter_muldiv;
   import iter_muldiv_pkg::*;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int unsigned  cyc;
      int unsigned  id;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned op_id = 0;
   exp_t        sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   iter_muldiv_if #(.WIDTH(W)) bus ();

   iter_muldiv #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.done === 1'b1) begin
         check("pending_op_at_done", 64'(sb.size() != 0), 64'd1);
         check("busy_at_done", 64'(bus.busy), 64'd0);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("op%0d_hi", e.id), 64'(bus.hi), 64'(e.hi));
            check($sformatf("op%0d_lo", e.id), 64'(bus.lo), 64'(e.lo));
            check($sformatf("op%0d_done_cycle", e.id), 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Launch one operation and register its expected result once accepted.
   task automatic run_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.srca  = a;
      bus.srcb  = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.srca  = '0;
      bus.srcb  = '0;
      e.hi  = exp_hi;
      e.lo  = exp_lo;
      e.cyc = cyc + W + 1;
      e.id  = op_id;
      op_id++;
      sb.push_back(e);
      check($sformatf("op%0d_busy_after_accept", e.id), 64'(bus.busy), 64'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #2;
         if (sb.size() == 0 && bus.busy == 1'b0) return;
      end
      check("drain_timeout_pending", 64'(sb.size()), 64'd0);
      check("drain_timeout_busy", 64'(bus.busy), 64'd0);
   endtask

   initial begin : watchdog
      #100us;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      bus.start  = 1'b0;
      bus.op     = OP_MULT;
      bus.srca   = '0;
      bus.srcb   = '0;
      bus.cancel = 1'b0;
      bus.hi_we  = 1'b0;
      bus.lo_we  = 1'b0;
      bus.wd     = '0;
      reset      = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      check("reset_hi", 64'(bus.hi), 64'd0);
      check("reset_lo", 64'(bus.lo), 64'd0);
      reset = 1'b1;

      run_op(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_idle();
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE); wait_idle();
      run_op(OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F); wait_idle();
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD); wait_idle();
      run_op(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD); wait_idle();
      run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);        wait_idle();
      run_op(OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF); wait_idle();
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000); wait_idle();
      run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000); wait_idle();
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF); wait_idle();

      // Start plus a HI write at cycle k+5 of a running MULT: both dropped.
      run_op(OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15);
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.srca  = 32'd7;
      bus.srcb  = 32'd9;
      bus.hi_we = 1'b1;
      bus.wd    = 32'h0BAD_0BAD;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      check("restart_busy", 64'(bus.busy), 64'd1);
      check("busy_write_dropped_hi", 64'(bus.hi), 64'hFFFF_FFF9);
      wait_idle();
      repeat (40) @(negedge clk);

      // Direct writes in IDLE: both together, then LO alone.
      @(negedge clk);
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wd    = 32'h5A5A_5A5A;
      @(posedge clk);
      #1;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      check("mt_both_hi", 64'(bus.hi), 64'h5A5A_5A5A);
      check("mt_both_lo", 64'(bus.lo), 64'h5A5A_5A5A);
      @(negedge clk);
      bus.lo_we = 1'b1;
      bus.wd    = 32'h2222_2222;
      @(posedge clk);
      #1;
      bus.lo_we = 1'b0;
      check("mtlo_hi_kept", 64'(bus.hi), 64'h5A5A_5A5A);
      check("mtlo_lo", 64'(bus.lo), 64'h2222_2222);

      // Cancel during cycle k+10: idle after edge k+11, no done, HI/LO kept.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.srca  = 32'h0000_1234;
      bus.srcb  = 32'h0000_0010;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("cancel_busy_after_accept", 64'(bus.busy), 64'd1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("cancel_busy_before", 64'(bus.busy), 64'd1);
      bus.cancel = 1'b1;
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      check("cancel_busy_after", 64'(bus.busy), 64'd0);
      check("cancel_done", 64'(bus.done), 64'd0);
      repeat (40) @(negedge clk);
      check("cancel_hi_kept", 64'(bus.hi), 64'h5A5A_5A5A);
      check("cancel_lo_kept", 64'(bus.lo), 64'h2222_2222);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_DIV;
      bus.srca  = 32'd1000;
      bus.srcb  = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_busy", 64'(bus.busy), 64'd0);
      check("async_reset_hi", 64'(bus.hi), 64'd0);
      check("async_reset_lo", 64'(bus.lo), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("post_reset_busy", 64'(bus.busy), 64'd0);

      // MTHI in IDLE, then MTLO together with start: write dropped, op runs.
      @(negedge clk);
      bus.hi_we = 1'b1;
      bus.wd    = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      bus.hi_we = 1'b0;
      check("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
      check("mthi_lo_kept", 64'(bus.lo), 64'd0);
      bus.lo_we = 1'b1;
      bus.wd    = 32'hCAFE_F00D;
      run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
      bus.lo_we = 1'b0;
      check("start_mtlo_dropped", 64'(bus.lo), 64'd0);
      wait_idle();
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
